seg7_monitor: RTL and testbench

Receive-side checker for the team's seven-segment digit output. It samples a 7-bit segment bus driven by an external seconds counter (or the looped-back uo_out[6:0]) and filters out glitches. It decodes the pattern back to a BCD digit and verifies the digit sequence 0,1,…,9,0. It reports each new digit, sequence errors, illegal codes and stalls, for use as an on-chip self-test or a tile-to-tile receiver.

---
 rtl/seg7_monitor.sv | 191 +++++++++++++++++++
 tb/tb_seg7_monitor.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_monitor.sv
// seg7_monitor: receive-side checker for the seven-segment digit bus.
// Synchronizes, deglitches, decodes and sequence-checks incoming digits.
module seg7_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 2047
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       locked,
  output logic       new_digit,
  output logic       seq_error,
  output logic       bad_code,
  output logic       stalled,
  output logic [7:0] error_count
);

  localparam logic [3:0]  STB = 4'(STABLE_CYCLES);
  localparam logic [11:0] TMO = 12'(TIMEOUT);

  typedef enum logic {
    SEARCH = 1'b0,
    TRACK  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  sync1_q, sync1_d;
  logic [6:0]  s_q, s_d;
  logic [6:0]  cand_q, cand_d;
  logic [6:0]  acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] timer_q, timer_d;
  logic [3:0]  digit_q, digit_d;
  logic        dv_q, dv_d;
  logic        nd_q, nd_d;
  logic        se_q, se_d;
  logic        bc_q, bc_d;
  logic        stalled_q, stalled_d;
  logic [7:0]  err_q, err_d;

  logic        accept;
  logic        dec_legal;
  logic        dec_blank;
  logic [3:0]  dec_digit;
  logic [3:0]  nxt_digit;
  logic        err_inc;

  // All state registers; reset wins over any coincident acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= SEARCH;
      sync1_q   <= 7'h00;
      s_q       <= 7'h00;
      cand_q    <= 7'h00;
      acc_q     <= 7'h00;
      cnt_q     <= 4'd0;
      timer_q   <= 12'd0;
      digit_q   <= 4'd0;
      dv_q      <= 1'b0;
      nd_q      <= 1'b0;
      se_q      <= 1'b0;
      bc_q      <= 1'b0;
      stalled_q <= 1'b0;
      err_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      s_q       <= s_d;
      cand_q    <= cand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      digit_q   <= digit_d;
      dv_q      <= dv_d;
      nd_q      <= nd_d;
      se_q      <= se_d;
      bc_q      <= bc_d;
      stalled_q <= stalled_d;
      err_q     <= err_d;
    end
  end

  // Two-flop synchronizer, then stability filter and acceptance.
  always_comb begin
    sync1_d = seg_in;
    s_d     = sync1_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    if (s_q != cand_q) begin
      cand_d = s_q;
      cnt_d  = 4'd1;
    end else if (cnt_q != STB) begin
      cnt_d = cnt_q + 4'd1;
    end
    accept = (cnt_q == STB) && (cand_q != acc_q);
    acc_d  = accept ? cand_q : acc_q;
  end

  // Segment pattern back to BCD; anything unlisted is illegal.
  always_comb begin
    dec_digit = 4'd0;
    dec_legal = 1'b1;
    case (cand_q)
      7'h3F: dec_digit = 4'd0;
      7'h06: dec_digit = 4'd1;
      7'h5B: dec_digit = 4'd2;
      7'h4F: dec_digit = 4'd3;
      7'h66: dec_digit = 4'd4;
      7'h6D: dec_digit = 4'd5;
      7'h7D: dec_digit = 4'd6;
      7'h07: dec_digit = 4'd7;
      7'h7F: dec_digit = 4'd8;
      7'h6F: dec_digit = 4'd9;
      default: dec_legal = 1'b0;
    endcase
  end

  assign dec_blank = (cand_q == 7'h00);
  assign nxt_digit = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;

  // Lock / track FSM reacting only to accepted patterns.
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    dv_d    = dv_q;
    nd_d    = 1'b0;
    se_d    = 1'b0;
    bc_d    = 1'b0;
    err_inc = 1'b0;
    if (accept) begin
      unique case (state_q)
        SEARCH: begin
          if (dec_legal) begin
            digit_d = dec_digit;
            dv_d    = 1'b1;
            state_d = TRACK;
          end else if (dec_blank) begin
            dv_d = 1'b0;
          end else begin
            bc_d    = 1'b1;
            err_inc = 1'b1;
            dv_d    = 1'b0;
          end
        end
        TRACK: begin
          if (dec_legal) begin
            if (dec_digit == nxt_digit) begin
              nd_d = 1'b1;
            end else begin
              se_d    = 1'b1;
              err_inc = 1'b1;
            end
            digit_d = dec_digit;
            dv_d    = 1'b1;
          end else if (dec_blank) begin
            dv_d    = 1'b0;
            state_d = SEARCH;
          end else begin
            bc_d    = 1'b1;
            err_inc = 1'b1;
            dv_d    = 1'b0;
            state_d = SEARCH;
          end
        end
      endcase
    end
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  // Stall timer: runs only while tracking, any acceptance restarts it.
  always_comb begin
    timer_d   = 12'd0;
    stalled_d = 1'b0;
    if (!accept && state_q == TRACK) begin
      timer_d   = (timer_q != TMO) ? timer_q + 12'd1 : timer_q;
      stalled_d = (timer_d == TMO);
    end
  end

  assign digit       = digit_q;
  assign digit_valid = dv_q;
  assign locked      = (state_q == TRACK);
  assign new_digit   = nd_q;
  assign seq_error   = se_q;
  assign bad_code    = bc_q;
  assign stalled     = stalled_q;
  assign error_count = err_q;

endmodule

// File: tb/tb_seg7_monitor.sv
// tb_seg7_monitor: randomized and directed bench for seg7_monitor.
// Reference model works on the per-edge history of seg_in.
module tb_seg7_monitor;

  localparam int S   = 4;
  localparam int TMO = 2047;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_in = 7'h00;
  logic [3:0] digit;
  logic       digit_valid;
  logic       locked;
  logic       new_digit;
  logic       seq_error;
  logic       bad_code;
  logic       stalled;
  logic [7:0] error_count;

  seg7_monitor #(
    .STABLE_CYCLES(S),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seg_in(seg_in),
    .digit(digit),
    .digit_valid(digit_valid),
    .locked(locked),
    .new_digit(new_digit),
    .seq_error(seq_error),
    .bad_code(bad_code),
    .stalled(stalled),
    .error_count(error_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [6:0] codes [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic [6:0] hist [$];
  logic [6:0] m_acc;
  bit m_locked, m_dv, m_nd, m_se, m_bc, m_stalled;
  int m_digit, m_err, m_since;
  int m_nd_n, m_se_n, m_bc_n;
  int o_nd_n, o_se_n, o_bc_n;
  int diverge;

  function automatic int dec(logic [6:0] v);
    for (int i = 0; i < 10; i++) if (codes[i] == v) return i;
    return (v == 7'h00) ? -1 : -2;
  endfunction

  task automatic step();
    logic [6:0] p;
    bit ok;
    int n, d;
    @(posedge clk);
    m_nd = 0; m_se = 0; m_bc = 0;
    if (!rst_n) begin
      hist.delete();
      for (int i = 0; i < S + 3; i++) hist.push_back(7'h00);
      m_acc = 7'h00; m_locked = 0; m_dv = 0;
      m_digit = 0; m_err = 0; m_since = 0;
    end else begin
      hist.push_back(seg_in);
      if (hist.size() > S + 8) void'(hist.pop_front());
      n = hist.size() - 1;
      p = hist[n-3];
      ok = (p != m_acc) && (hist[n-S-3] != p);
      for (int i = n - S - 2; i <= n - 3; i++) if (hist[i] != p) ok = 0;
      if (m_since < 100000) m_since++;
      if (ok) begin
        m_acc = p;
        m_since = 0;
        d = dec(p);
        if (d >= 0) begin
          if (m_locked) begin
            if (d == (m_digit + 1) % 10) m_nd = 1;
            else begin m_se = 1; m_err++; end
          end
          m_locked = 1; m_digit = d; m_dv = 1;
        end else if (d == -1) begin
          m_dv = 0; m_locked = 0;
        end else begin
          m_bc = 1; m_err++; m_dv = 0; m_locked = 0;
        end
      end
      if (m_err > 255) m_err = 255;
    end
    m_stalled = m_locked && (m_since >= TMO);
    m_nd_n += int'(m_nd); m_se_n += int'(m_se); m_bc_n += int'(m_bc);
    #1;
    if (new_digit === 1'b1) o_nd_n++;
    if (seq_error === 1'b1) o_se_n++;
    if (bad_code === 1'b1) o_bc_n++;
    if ({digit, digit_valid, locked, new_digit, seq_error, bad_code,
         stalled, error_count} !==
        {4'(m_digit), m_dv, m_locked, m_nd, m_se, m_bc,
         m_stalled, 8'(m_err)}) diverge++;
  endtask

  task automatic hold(input logic [6:0] v, input int n);
    seg_in = v;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    seg_in = 7'h00;
    diverge = 0;
    repeat (3) step();
    checks++; if (digit !== 4'd0) begin failures++; $display("FAIL reset_digit got=%0d want=0", digit); end
    checks++; if (digit_valid !== 1'b0) begin failures++; $display("FAIL reset_dv got=%b want=0", digit_valid); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b want=0", locked); end
    checks++; if ({new_digit, seq_error, bad_code} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b want=000", {new_digit, seq_error, bad_code}); end
    checks++; if (stalled !== 1'b0) begin failures++; $display("FAIL reset_stalled got=%b want=0", stalled); end
    checks++; if (error_count !== 8'd0) begin failures++; $display("FAIL reset_errcnt got=%0d want=0", error_count); end
  endtask

  task automatic test_lock();
    int nd0 = o_nd_n, se0 = o_se_n, bc0 = o_bc_n;
    diverge = 0;
    rst_n = 1'b1;
    seg_in = 7'h3F;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == S + 2) begin
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL lock_early locked=%b want=0", locked); end
      end
      if (i == S + 3) begin
        checks++; if ({locked, digit_valid, digit} !== {1'b1, 1'b1, 4'd0}) begin failures++; $display("FAIL lock_edge got=%b/%b/%0d want=1/1/0", locked, digit_valid, digit); end
      end
    end
    checks++; if ((o_nd_n - nd0) + (o_se_n - se0) + (o_bc_n - bc0) !== 0) begin failures++; $display("FAIL lock_pulses got=%0d want=0", (o_nd_n - nd0) + (o_se_n - se0) + (o_bc_n - bc0)); end
    checks++; if (diverge !== 0) begin failures++; $display("FAIL lock_model diverged=%0d want=0", diverge); end
  endtask

  task automatic test_sequence();
    int nd0 = o_nd_n;
    diverge = 0;
    for (int k = 1; k <= 10; k++) hold(codes[k % 10], 20);
    checks++; if (o_nd_n - nd0 !== 10) begin failures++; $display("FAIL seq_new_digits got=%0d want=10", o_nd_n - nd0); end
    checks++; if (digit !== 4'd0) begin failures++; $display("FAIL seq_wrap_digit got=%0d want=0", digit); end
    checks++; if (error_count !== 8'd0) begin failures++; $display("FAIL seq_errcnt got=%0d want=0", error_count); end
    checks++; if (diverge !== 0) begin failures++; $display("FAIL seq_model diverged=%0d want=0", diverge); end
  endtask

  task automatic test_seq_error();
    int se0, nd0;
    diverge = 0;
    do_reset();
    hold(7'h3F, 10); hold(7'h06, 10); hold(7'h5B, 10); hold(7'h4F, 10);
    se0 = o_se_n;
    hold(7'h6D, 10);
    checks++; if (o_se_n - se0 !== 1) begin failures++; $display("FAIL seqerr_pulse got=%0d want=1", o_se_n - se0); end
    checks++; if (error_count !== 8'd1) begin failures++; $display("FAIL seqerr_count got=%0d want=1", error_count); end
    checks++; if (digit !== 4'd5) begin failures++; $display("FAIL seqerr_digit got=%0d want=5", digit); end
    nd0 = o_nd_n;
    hold(7'h7D, 10);
    checks++; if (o_nd_n - nd0 !== 1 || digit !== 4'd6) begin failures++; $display("FAIL seqerr_resync nd=%0d digit=%0d want 1/6", o_nd_n - nd0, digit); end
    checks++; if (diverge !== 0) begin failures++; $display("FAIL seqerr_model diverged=%0d want=0", diverge); end
  endtask

  task automatic test_glitch();
    int tot0;
    diverge = 0;
    do_reset();
    hold(7'h66, 10);
    tot0 = o_nd_n + o_se_n + o_bc_n;
    hold(7'h7F, S - 1);
    hold(7'h66, 10);
    checks++; if (o_nd_n + o_se_n + o_bc_n - tot0 !== 0) begin failures++; $display("FAIL glitch_pulses got=%0d want=0", o_nd_n + o_se_n + o_bc_n - tot0); end
    checks++; if ({locked, digit} !== {1'b1, 4'd4}) begin failures++; $display("FAIL glitch_digit got=%b/%0d want=1/4", locked, digit); end
    checks++; if (diverge !== 0) begin failures++; $display("FAIL glitch_model diverged=%0d want=0", diverge); end
  endtask

  task automatic test_bad_code();
    int bc0;
    diverge = 0;
    do_reset();
    hold(7'h3F, 10);
    bc0 = o_bc_n;
    hold(7'h55, 10);
    checks++; if (o_bc_n - bc0 !== 1) begin failures++; $display("FAIL bad_pulse got=%0d want=1", o_bc_n - bc0); end
    checks++; if ({locked, digit_valid, error_count} !== {1'b0, 1'b0, 8'd1}) begin failures++; $display("FAIL bad_state got=%b/%b/%0d want=0/0/1", locked, digit_valid, error_count); end
    hold(7'h00, 10);
    checks++; if (error_count !== 8'd1 || o_bc_n - bc0 !== 1) begin failures++; $display("FAIL blank_noerr cnt=%0d bc=%0d want 1/1", error_count, o_bc_n - bc0); end
    for (int k = 0; k < 300; k++) hold((k % 2 == 0) ? 7'h56 : 7'h55, S);
    checks++; if (error_count !== 8'd255) begin failures++; $display("FAIL err_saturate got=%0d want=255", error_count); end
    checks++; if (diverge !== 0) begin failures++; $display("FAIL bad_model diverged=%0d want=0", diverge); end
  endtask

  task automatic lock_zero();
    do_reset();
    seg_in = 7'h3F;
    for (int i = 0; i < 20 && !m_locked; i++) step();
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_bound locked=%b want=1", locked); end
  endtask

  task automatic test_stall();
    int nd0;
    diverge = 0;
    lock_zero();
    for (int i = 1; i <= TMO; i++) begin
      step();
      if (i == TMO - 1) begin
        checks++; if (stalled !== 1'b0) begin failures++; $display("FAIL stall_early got=%b want=0", stalled); end
      end
      if (i == TMO) begin
        checks++; if ({stalled, locked} !== 2'b11) begin failures++; $display("FAIL stall_set got=%b/%b want=1/1", stalled, locked); end
      end
    end
    nd0 = o_nd_n;
    hold(7'h06, S + 3);
    checks++; if ({new_digit, stalled} !== 2'b10 || o_nd_n - nd0 !== 1) begin failures++; $display("FAIL stall_clear got nd=%b st=%b want 1/0", new_digit, stalled); end
    rst_n = 1'b0;
    step();
    checks++; if ({digit, digit_valid, locked, new_digit, seq_error, bad_code, stalled, error_count} !== 19'd0) begin failures++; $display("FAIL reset_in_pulse got=%h want=0", {digit, digit_valid, locked, new_digit, seq_error, bad_code, stalled, error_count}); end
    rst_n = 1'b1;
    checks++; if (diverge !== 0) begin failures++; $display("FAIL stall_model diverged=%0d want=0", diverge); end
  endtask

  task automatic test_accept_vs_timeout();
    diverge = 0;
    lock_zero();
    repeat (TMO - S - 3) step();
    hold(7'h06, S + 3);
    checks++; if ({new_digit, stalled, locked} !== 3'b101) begin failures++; $display("FAIL acc_vs_tmo got=%b want=101", {new_digit, stalled, locked}); end
    step();
    checks++; if (stalled !== 1'b0) begin failures++; $display("FAIL acc_vs_tmo_after got=%b want=0", stalled); end
    checks++; if (diverge !== 0) begin failures++; $display("FAIL acctmo_model diverged=%0d want=0", diverge); end
  endtask

  task automatic test_reset_accept();
    diverge = 0;
    do_reset();
    hold(7'h3F, S + 2);
    rst_n = 1'b0;
    step();
    checks++; if ({locked, digit_valid} !== 2'b00) begin failures++; $display("FAIL rst_vs_accept got=%b want=00", {locked, digit_valid}); end
    rst_n = 1'b1;
    hold(7'h3F, S + 2);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL relock_early got=%b want=0", locked); end
    step();
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL relock got=%b want=1", locked); end
    checks++; if (diverge !== 0) begin failures++; $display("FAIL rstacc_model diverged=%0d want=0", diverge); end
  endtask

  task automatic test_random();
    int nd0, se0, bc0, mnd0, mse0, mbc0, k, len;
    logic [6:0] v;
    diverge = 0;
    do_reset();
    nd0 = o_nd_n; se0 = o_se_n; bc0 = o_bc_n;
    mnd0 = m_nd_n; mse0 = m_se_n; mbc0 = m_bc_n;
    for (int seg = 0; seg < 300; seg++) begin
      k = $urandom_range(0, 9);
      len = $urandom_range(1, 12);
      v = codes[(m_digit + 1) % 10];
      if (k == 5) v = codes[$urandom_range(0, 9)];
      if (k == 6) v = 7'h00;
      if (k == 7) begin
        v = 7'($urandom);
        while (dec(v) != -2) v = 7'($urandom);
      end
      if (k == 8) begin
        v = 7'($urandom);
        len = $urandom_range(1, S - 1);
      end
      if (k == 9 && $urandom_range(0, 3) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        hold(v, len);
      end
    end
    checks++; if (o_nd_n - nd0 !== m_nd_n - mnd0) begin failures++; $display("FAIL rand_new_digit got=%0d want=%0d", o_nd_n - nd0, m_nd_n - mnd0); end
    checks++; if (o_se_n - se0 !== m_se_n - mse0) begin failures++; $display("FAIL rand_seq_error got=%0d want=%0d", o_se_n - se0, m_se_n - mse0); end
    checks++; if (o_bc_n - bc0 !== m_bc_n - mbc0) begin failures++; $display("FAIL rand_bad_code got=%0d want=%0d", o_bc_n - bc0, m_bc_n - mbc0); end
    checks++; if (diverge !== 0) begin failures++; $display("FAIL rand_model diverged=%0d want=0", diverge); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_sequence();
    test_seq_error();
    test_glitch();
    test_bad_code();
    test_stall();
    test_accept_vs_timeout();
    test_reset_accept();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
